// File: rtl/y_row_writer_pkg.sv
// Shared Y-memory definitions: geometry, index-line pointer layout and the row-writer state set.
package y_row_writer_pkg;

   localparam int unsigned ADDR_W       = 11;
   localparam int unsigned LINE_W       = 256;
   localparam int unsigned PTR_PER_LINE = 16;
   localparam int unsigned PTR_W        = 16;

   localparam logic [15:0] Y_STREAM_ROW = 16'hFFFF;
   localparam logic [10:0] Y_UNMAPPED   = 11'h7FF;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_IDX   = 3'd1,
      WAIT_IDX = 3'd2,
      WR0      = 3'd3,
      WR1      = 3'd4,
      DONE     = 3'd5
   } yRwState_t;

endpackage

// File: rtl/y_ptr_select.sv
// Picks one 16-bit pointer slot out of an index line and returns its line-address bits.
module y_ptr_select #(
   parameter int unsigned LINE_W = 256,
   parameter int unsigned ADDR_W = 11
) (
   input  logic [LINE_W-1:0] line,
   input  logic [3:0]        slot,
   output logic [ADDR_W-1:0] ptr
);
   import y_row_writer_pkg::*;

   // Upper bits of each slot are reserved; only the address bits are taken.
   always_comb begin
      ptr = line[slot*PTR_W +: ADDR_W];
   end

endmodule

// File: rtl/y_row_writer.sv
// Writes a two-line Y row either through the per-row index table or to a sequential stream pointer.
module y_row_writer #(
   parameter int unsigned ADDR_W = y_row_writer_pkg::ADDR_W,
   parameter int unsigned LINE_W = y_row_writer_pkg::LINE_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              yRW_start,
   output logic              yRW_ready,
   input  logic [15:0]       yRW_rowNum,
   input  logic [LINE_W-1:0] yRW_line0,
   input  logic [LINE_W-1:0] yRW_line1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rdEn,
   input  logic [LINE_W-1:0] mem_rdData,
   output logic              mem_wrEn,
   output logic [LINE_W-1:0] mem_wrData,
   output logic              yRW_done,
   output logic              yRW_err
);
   import y_row_writer_pkg::*;

   localparam logic [ADDR_W-1:0] UNMAPPED_ADDR = ADDR_W'(Y_UNMAPPED);

   yRwState_t         stateQ, stateD;
   logic [15:0]       rowNumQ, rowNumD;
   logic [LINE_W-1:0] line0Q, line0D, line1Q, line1D;
   logic [ADDR_W-1:0] ptrQ, ptrD, seqPtrQ, seqPtrD, idxPtr;
   logic              errQ, errD;

   logic [ADDR_W-1:0] addrD;
   logic [LINE_W-1:0] wrDataD;
   logic              rdEnD, wrEnD, doneD, errOutD, readyD;

   y_ptr_select #(
      .LINE_W(LINE_W),
      .ADDR_W(ADDR_W)
   ) uPtrSelect (
      .line(mem_rdData),
      .slot(rowNumQ[3:0]),
      .ptr (idxPtr)
   );

   always_comb begin : nextState
      stateD  = stateQ;
      rowNumD = rowNumQ;
      line0D  = line0Q;
      line1D  = line1Q;
      ptrD    = ptrQ;
      seqPtrD = seqPtrQ;
      errD    = errQ;
      case (stateQ)
         IDLE: begin
            if (yRW_start) begin
               rowNumD = yRW_rowNum;
               line0D  = yRW_line0;
               line1D  = yRW_line1;
               errD    = 1'b0;
               if (yRW_rowNum == Y_STREAM_ROW) begin
                  ptrD   = seqPtrQ;
                  stateD = WR0;
               end else begin
                  stateD = RD_IDX;
               end
            end
         end
         RD_IDX:   stateD = WAIT_IDX;
         WAIT_IDX: begin
            ptrD = idxPtr;
            if (idxPtr == UNMAPPED_ADDR) begin
               errD   = 1'b1;
               stateD = DONE;
            end else begin
               stateD = WR0;
            end
         end
         WR0:      stateD = WR1;
         WR1: begin
            stateD = DONE;
            if (rowNumQ == Y_STREAM_ROW) seqPtrD = seqPtrQ + ADDR_W'(2);
         end
         DONE:     stateD = IDLE;
         default:  stateD = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every port comes straight off a flop.
   always_comb begin : nextOutputs
      addrD   = UNMAPPED_ADDR;
      wrDataD = '0;
      case (stateD)
         RD_IDX: addrD = ADDR_W'(rowNumD[14:4]);
         WR0: begin
            addrD   = ptrD;
            wrDataD = line0D;
         end
         WR1: begin
            addrD   = ptrD + ADDR_W'(1);
            wrDataD = line1D;
         end
         default: ;
      endcase
      rdEnD   = (stateD == RD_IDX);
      wrEnD   = (stateD == WR0) || (stateD == WR1);
      doneD   = (stateD == DONE);
      errOutD = (stateD == DONE) && errD;
      readyD  = (stateD == IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stateQ     <= IDLE;
         rowNumQ    <= '0;
         line0Q     <= '0;
         line1Q     <= '0;
         ptrQ       <= '0;
         seqPtrQ    <= '0;
         errQ       <= 1'b0;
         mem_addr   <= UNMAPPED_ADDR;
         mem_wrData <= '0;
         mem_rdEn   <= 1'b0;
         mem_wrEn   <= 1'b0;
         yRW_done   <= 1'b0;
         yRW_err    <= 1'b0;
         yRW_ready  <= 1'b1;
      end else begin
         stateQ     <= stateD;
         rowNumQ    <= rowNumD;
         line0Q     <= line0D;
         line1Q     <= line1D;
         ptrQ       <= ptrD;
         seqPtrQ    <= seqPtrD;
         errQ       <= errD;
         mem_addr   <= addrD;
         mem_wrData <= wrDataD;
         mem_rdEn   <= rdEnD;
         mem_wrEn   <= wrEnD;
         yRW_done   <= doneD;
         yRW_err    <= errOutD;
         yRW_ready  <= readyD;
      end
   end

endmodule

// File: tb/tb_y_row_writer.sv
// Randomised bench for y_row_writer: a behavioural Y-memory plus a transaction-level reference model.
module tb_y_row_writer;

   localparam int ADDR_W = 11;
   localparam int LINE_W = 256;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              yRW_start = 1'b0;
   logic              yRW_ready;
   logic [15:0]       yRW_rowNum = '0;
   logic [LINE_W-1:0] yRW_line0 = '0;
   logic [LINE_W-1:0] yRW_line1 = '0;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rdEn;
   logic [LINE_W-1:0] mem_rdData = '0;
   logic              mem_wrEn;
   logic [LINE_W-1:0] mem_wrData;
   logic              yRW_done;
   logic              yRW_err;

   y_row_writer #(
      .ADDR_W(ADDR_W),
      .LINE_W(LINE_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .yRW_start (yRW_start),
      .yRW_ready (yRW_ready),
      .yRW_rowNum(yRW_rowNum),
      .yRW_line0 (yRW_line0),
      .yRW_line1 (yRW_line1),
      .mem_addr  (mem_addr),
      .mem_rdEn  (mem_rdEn),
      .mem_rdData(mem_rdData),
      .mem_wrEn  (mem_wrEn),
      .mem_wrData(mem_wrData),
      .yRW_done  (yRW_done),
      .yRW_err   (yRW_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      int           cyc;
      logic [10:0]  addr;
      logic [255:0] data;
   } memEvent_t;
   typedef memEvent_t evQueue_t[$];

   evQueue_t gotWr, expWr, gotRd, expRd, gotDone, expDone;

   logic [255:0] simMem [0:2047];
   logic [255:0] refMem [0:2047];
   logic [10:0]  refSeq = '0;

   int numChecks = 0;
   int numPass = 0;
   bit monitorOn = 1'b0;
   int overlapCount = 0;
   int idleBusCount = 0;

   // Y-memory: read data appears the cycle after the strobe.
   always @(posedge clock) begin
      if (mem_rdEn) mem_rdData <= simMem[mem_addr];
      if (mem_wrEn) simMem[mem_addr] <= mem_wrData;
   end

   always @(negedge clock) begin
      if (monitorOn) begin
         if (mem_rdEn && mem_wrEn) overlapCount++;
         if (!mem_rdEn && !mem_wrEn && (mem_addr != 11'h7FF || mem_wrData != '0)) idleBusCount++;
      end
   end

   task automatic checkValue(input string tag, input logic [255:0] got, input logic [255:0] exp);
      numChecks++;
      if (got === exp) numPass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [255:0] randLine();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic setSlot(input int lineIdx, input int slot, input logic [15:0] val);
      simMem[lineIdx][slot*16 +: 16] = val;
      refMem[lineIdx][slot*16 +: 16] = val;
   endtask

   task automatic pushEvent(inout evQueue_t q, input int cyc, input logic [10:0] a,
                            input logic [255:0] d);
      memEvent_t e;
      e.cyc  = cyc;
      e.addr = a;
      e.data = d;
      q.push_back(e);
   endtask

   // Expected strobes of one transaction, with cycle numbers counted from its accepting edge.
   task automatic modelTxn(input logic [15:0] row, input logic [255:0] l0, input logic [255:0] l1,
                           input int base);
      logic [10:0]  p;
      logic [10:0]  p1;
      logic [255:0] slotVal;
      if (row == 16'hFFFF) begin
         p = refSeq;
         refSeq = refSeq + 11'd2;
      end else begin
         slotVal = refMem[row[14:4]] >> (16 * row[3:0]);
         p = slotVal[10:0];
         pushEvent(expRd, base + 1, row[14:4], '0);
         if (p == 11'h7FF) begin
            pushEvent(expDone, base + 3, '0, 256'd1);
            return;
         end
         base = base + 2;
      end
      p1 = p + 11'd1;
      pushEvent(expWr, base + 1, p, l0);
      pushEvent(expWr, base + 2, p1, l1);
      pushEvent(expDone, base + 3, '0, 256'd0);
      refMem[p]  = l0;
      refMem[p1] = l1;
   endtask

   task automatic compareEvents(input string name, input evQueue_t got, input evQueue_t exp);
      checkValue({name, ".count"}, got.size(), exp.size());
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
         checkValue($sformatf("%s[%0d].cyc", name, i), got[i].cyc, exp[i].cyc);
         checkValue($sformatf("%s[%0d].addr", name, i), got[i].addr, exp[i].addr);
         checkValue($sformatf("%s[%0d].data", name, i), got[i].data, exp[i].data);
      end
   endtask

   task automatic clearEvents();
      gotWr.delete();
      expWr.delete();
      gotRd.delete();
      expRd.delete();
      gotDone.delete();
      expDone.delete();
   endtask

   task automatic capture(input int window, input int releaseAt);
      for (int k = 1; k <= window; k++) begin
         @(negedge clock);
         if (k == 1) checkValue("busyReady", yRW_ready, 1'b0);
         if (mem_wrEn) pushEvent(gotWr, k, mem_addr, mem_wrData);
         if (mem_rdEn) pushEvent(gotRd, k, mem_addr, '0);
         if (yRW_done) pushEvent(gotDone, k, '0, {255'd0, yRW_err});
         if (k == releaseAt) yRW_start = 1'b0;
      end
   endtask

   task automatic compareAll();
      compareEvents("write", gotWr, expWr);
      compareEvents("read", gotRd, expRd);
      compareEvents("done", gotDone, expDone);
   endtask

   task automatic waitReady();
      int n = 0;
      while (!yRW_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      checkValue("readyWait", yRW_ready, 1'b1);
   endtask

   task automatic driveStart(input logic [15:0] row, input logic [255:0] l0, input logic [255:0] l1);
      yRW_start  = 1'b1;
      yRW_rowNum = row;
      yRW_line0  = l0;
      yRW_line1  = l1;
   endtask

   task automatic runTxn(input logic [15:0] row);
      logic [255:0] l0;
      logic [255:0] l1;
      l0 = randLine();
      l1 = randLine();
      waitReady();
      clearEvents();
      driveStart(row, l0, l1);
      modelTxn(row, l0, l1, 0);
      capture(6, 1);
      compareAll();
   endtask

   initial begin
      logic [255:0] l0;
      logic [255:0] l1;
      logic [15:0]  row;
      int           stray;

      for (int i = 0; i < 2048; i++) begin
         l0 = randLine();
         simMem[i] = l0;
         refMem[i] = l0;
      end

      repeat (3) @(posedge clock);
      @(negedge clock);
      checkValue("rstReady", yRW_ready, 1'b1);
      checkValue("rstRdEn", mem_rdEn, 1'b0);
      checkValue("rstWrEn", mem_wrEn, 1'b0);
      checkValue("rstDone", yRW_done, 1'b0);
      checkValue("rstErr", yRW_err, 1'b0);
      checkValue("rstAddr", mem_addr, 11'h7FF);
      checkValue("rstWrData", mem_wrData, '0);
      reset = 1'b0;
      monitorOn = 1'b1;
      @(negedge clock);

      // Stream mode from reset: 000/001, 002/003, 004/005.
      repeat (3) runTxn(16'hFFFF);

      // Mapped row: index line 2 slot 3 points at 0x140.
      setSlot(2, 3, 16'h0140);
      runTxn(16'h0023);

      // Unmapped rows, including reserved upper slot bits set.
      setSlot(5, 7, 16'h07FF);
      runTxn(16'h0057);
      setSlot(6, 1, 16'hF7FF);
      runTxn(16'h0061);

      // Pointer 7FE writes 7FE then 7FF.
      setSlot(9, 10, 16'h07FE);
      runTxn(16'h009A);

      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(3) == 0) row = 16'hFFFF;
         else begin
            row = 16'($urandom);
            if (row == 16'hFFFF) row = 16'h0000;
         end
         runTxn(row);
      end

      // Start held high: one transaction, then a second only once back in IDLE.
      l0 = randLine();
      l1 = randLine();
      waitReady();
      clearEvents();
      driveStart(16'hFFFF, l0, l1);
      modelTxn(16'hFFFF, l0, l1, 0);
      modelTxn(16'hFFFF, l0, l1, 4);
      capture(8, 5);
      compareAll();

      // Reset during WR0 aborts the transaction.
      l0 = randLine();
      l1 = randLine();
      waitReady();
      driveStart(16'hFFFF, l0, l1);
      @(negedge clock);
      checkValue("abortWr0Strobe", mem_wrEn, 1'b1);
      checkValue("abortWr0Addr", mem_addr, refSeq);
      refMem[refSeq] = l0;
      refSeq = '0;
      yRW_start = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      checkValue("abortReady", yRW_ready, 1'b1);
      checkValue("abortRdEn", mem_rdEn, 1'b0);
      checkValue("abortWrEn", mem_wrEn, 1'b0);
      checkValue("abortDone", yRW_done, 1'b0);
      checkValue("abortErr", yRW_err, 1'b0);
      checkValue("abortAddr", mem_addr, 11'h7FF);
      checkValue("abortWrData", mem_wrData, '0);
      reset = 1'b0;
      stray = 0;
      repeat (3) begin
         @(negedge clock);
         if (mem_wrEn || mem_rdEn || yRW_done) stray++;
      end
      checkValue("abortQuiet", stray, 0);
      runTxn(16'hFFFF);

      // Walk the stream pointer up to 7FE and through the wrap.
      while (refSeq != 11'h7FE) runTxn(16'hFFFF);
      runTxn(16'hFFFF);
      runTxn(16'hFFFF);

      monitorOn = 1'b0;
      checkValue("strobeOverlap", overlapCount, 0);
      checkValue("idleBus", idleBusCount, 0);

      $display("%0d/%0d checks passed", numPass, numChecks);
      $finish;
   end

endmodule
